// File: rtl/axi_wr_mem_slave.sv
// axi_wr_mem_slave
//   AXI write-channel memory target. Accepts one AW burst at a time, stores the
//   W beats (byte strobes) into an internal RAM and returns one B response.
//   A combinational debug port exposes RAM contents without an AXI read path.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   axi_aw_*                      write address channel (id/addr/len/size/burst/valid/ready)
//   axi_w_*                       write data channel (data/strb/last/valid/ready)
//   axi_b_*                       write response channel (id/resp/valid/ready)
//   dbg_addr_i / dbg_data_o       debug word index / RAM word at that index
//
// state  | meaning
// S_IDLE | aw_ready high, waiting for an AW handshake
// S_DATA | w_ready high, writing beats until WLAST or beat count reaches len
// S_WAIT | response latency timer running down
// S_RESP | b_valid high, response held until b_ready
module axi_wr_mem_slave #(
  parameter int          DW        = 64,
  parameter int          AW        = 32,
  parameter int          TIDW      = 1,
  parameter int          MEM_DEPTH = 256,
  parameter int unsigned BASE_ADDR = 0,
  parameter int          B_LAT     = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [TIDW-1:0]              axi_aw_id_i,
  input  logic [AW-1:0]                axi_aw_addr_i,
  input  logic [7:0]                   axi_aw_len_i,
  input  logic [2:0]                   axi_aw_size_i,
  input  logic [1:0]                   axi_aw_burst_i,
  input  logic                         axi_aw_valid_i,
  output logic                         axi_aw_ready_o,
  input  logic [DW-1:0]                axi_w_data_i,
  input  logic [DW/8-1:0]              axi_w_strb_i,
  input  logic                         axi_w_last_i,
  input  logic                         axi_w_valid_i,
  output logic                         axi_w_ready_o,
  output logic [TIDW-1:0]              axi_b_id_o,
  output logic [1:0]                   axi_b_resp_o,
  output logic                         axi_b_valid_o,
  input  logic                         axi_b_ready_i,
  input  logic [$clog2(MEM_DEPTH)-1:0] dbg_addr_i,
  output logic [DW-1:0]                dbg_data_o
);

  localparam int LG   = $clog2(DW/8);
  localparam int IDXW = $clog2(MEM_DEPTH);
  localparam int LATW = $clog2(B_LAT) + 1;
  localparam logic [AW-1:0] BASE_C = AW'(BASE_ADDR);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic              aw_ready_q, w_ready_q, b_valid_q;
  logic [TIDW-1:0]   b_id_q;
  logic [1:0]        b_resp_q;
  logic [AW-1:0]     beat_addr_q;
  logic [7:0]        len_q, beat_cnt_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic              err_q, cfg_err_q;
  logic [LATW-1:0]   lat_cnt_q;
  logic [DW-1:0]     mem [MEM_DEPTH];

  logic              aw_hs, w_hs, b_hs, beat_last, burst_end, lat_done;
  logic              cfg_bad_in, addr_err, we;
  logic [AW-1:0]     align_mask, step, wrap_mask, incr_addr, next_addr, off, word_full;
  logic [AW:0]       diff;
  logic [IDXW-1:0]   word_idx;

  assign aw_hs     = axi_aw_valid_i && aw_ready_q;
  assign w_hs      = axi_w_valid_i && w_ready_q;
  assign b_hs      = b_valid_q && axi_b_ready_i;
  assign beat_last = (beat_cnt_q == len_q);
  assign burst_end = w_hs && (axi_w_last_i || beat_last);
  assign lat_done  = (lat_cnt_q == '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (aw_hs)     state_d = S_DATA;
      S_DATA: if (burst_end) state_d = S_WAIT;
      S_WAIT: if (lat_done)  state_d = S_RESP;
      S_RESP: if (b_hs)      state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  // Burst configuration check on the incoming AW beat.
  always_comb begin
    align_mask = (AW'(1) << axi_aw_size_i) - AW'(1);
    cfg_bad_in = (axi_aw_burst_i == 2'b11) || (axi_aw_size_i > 3'(LG)) ||
                 ((axi_aw_burst_i == 2'b10) &&
                  (!((axi_aw_len_i == 8'd1) || (axi_aw_len_i == 8'd3) ||
                     (axi_aw_len_i == 8'd7) || (axi_aw_len_i == 8'd15)) ||
                   ((axi_aw_addr_i & align_mask) != '0)));
  end

  // Beat address sequencing and RAM word mapping; diff carries a borrow bit
  // so addresses below BASE_ADDR are caught without a signed compare.
  always_comb begin
    step      = AW'(1) << size_q;
    wrap_mask = ((AW'(len_q) + AW'(1)) << size_q) - AW'(1);
    incr_addr = beat_addr_q + step;
    case (burst_q)
      2'b00:   next_addr = beat_addr_q;
      2'b10:   next_addr = (beat_addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default: next_addr = incr_addr;
    endcase
    diff      = {1'b0, beat_addr_q} - {1'b0, BASE_C};
    off       = diff[AW-1:0];
    word_full = off >> LG;
    addr_err  = diff[AW] || (word_full >= AW'(MEM_DEPTH));
    word_idx  = word_full[IDXW-1:0];
    we        = w_hs && !cfg_err_q && !addr_err;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_ready_q  <= 1'b0;
      w_ready_q   <= 1'b0;
      b_valid_q   <= 1'b0;
      b_id_q      <= '0;
      b_resp_q    <= 2'b00;
      beat_addr_q <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
      cfg_err_q   <= 1'b0;
      lat_cnt_q   <= '0;
    end else begin
      // Handshake outputs are registered from the next state so they line up
      // with the state they belong to.
      aw_ready_q <= (state_d == S_IDLE);
      w_ready_q  <= (state_d == S_DATA);
      b_valid_q  <= (state_d == S_RESP);
      if (aw_hs) begin
        b_id_q      <= axi_aw_id_i;
        beat_addr_q <= axi_aw_addr_i;
        len_q       <= axi_aw_len_i;
        size_q      <= axi_aw_size_i;
        burst_q     <= axi_aw_burst_i;
        beat_cnt_q  <= '0;
        cfg_err_q   <= cfg_bad_in;
        err_q       <= cfg_bad_in;
      end
      if (w_hs) begin
        beat_cnt_q  <= beat_cnt_q + 8'd1;
        beat_addr_q <= next_addr;
        if (addr_err || (axi_w_last_i != beat_last)) err_q <= 1'b1;
      end
      // Timer loaded with B_LAT-1 so b_valid rises B_LAT cycles after the final beat.
      if ((state_q == S_DATA) && burst_end)
        lat_cnt_q <= LATW'(B_LAT - 1);
      else if ((state_q == S_WAIT) && !lat_done)
        lat_cnt_q <= lat_cnt_q - LATW'(1);
      if ((state_q == S_WAIT) && lat_done)
        b_resp_q <= err_q ? 2'b10 : 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DW/8; i++)
      if (we && axi_w_strb_i[i])
        mem[word_idx][i*8 +: 8] <= axi_w_data_i[i*8 +: 8];
  end

  assign dbg_data_o     = mem[dbg_addr_i];
  assign axi_aw_ready_o = aw_ready_q;
  assign axi_w_ready_o  = w_ready_q;
  assign axi_b_valid_o  = b_valid_q;
  assign axi_b_id_o     = b_id_q;
  assign axi_b_resp_o   = b_resp_q;

endmodule

// File: tb/tb_axi_wr_mem_slave.sv
module tb_axi_wr_mem_slave;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [0:0]  aw_id = '0;
  logic [31:0] aw_addr = '0;
  logic [7:0]  aw_len = '0;
  logic [2:0]  aw_size = '0;
  logic [1:0]  aw_burst = '0;
  logic        aw_valid = 1'b0;
  logic        aw_ready;
  logic [63:0] w_data = '0;
  logic [7:0]  w_strb = '0;
  logic        w_last = 1'b0;
  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [0:0]  b_id;
  logic [1:0]  b_resp;
  logic        b_valid;
  logic        b_ready = 1'b0;
  logic [7:0]  dbg_addr = '0;
  logic [63:0] dbg_data;

  int total = 0;
  int bad = 0;

  axi_wr_mem_slave dut (
    .clk(clk), .rst(rst),
    .axi_aw_id_i(aw_id), .axi_aw_addr_i(aw_addr), .axi_aw_len_i(aw_len),
    .axi_aw_size_i(aw_size), .axi_aw_burst_i(aw_burst),
    .axi_aw_valid_i(aw_valid), .axi_aw_ready_o(aw_ready),
    .axi_w_data_i(w_data), .axi_w_strb_i(w_strb), .axi_w_last_i(w_last),
    .axi_w_valid_i(w_valid), .axi_w_ready_o(w_ready),
    .axi_b_id_o(b_id), .axi_b_resp_o(b_resp), .axi_b_valid_o(b_valid),
    .axi_b_ready_i(b_ready),
    .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input int idx, input logic [63:0] exp, input string tag);
    dbg_addr = idx[7:0];
    #1;
    chk(tag, dbg_data, exp);
  endtask

  task automatic aw_send(input logic [0:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    aw_id = id; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst;
    aw_valid = 1'b1;
    while (!aw_ready && n < 30) begin tick(); n++; end
    chk("aw_wait_bound", 64'(n < 30), 64'd1);
    tick();
    aw_valid = 1'b0;
  endtask

  task automatic w_send(input logic [63:0] data, input logic [7:0] strb, input logic last);
    int n = 0;
    w_data = data; w_strb = strb; w_last = last; w_valid = 1'b1;
    while (!w_ready && n < 30) begin tick(); n++; end
    chk("w_wait_bound", 64'(n < 30), 64'd1);
    tick();
    w_valid = 1'b0; w_last = 1'b0;
  endtask

  task automatic finish_b(input logic [1:0] er, input logic [0:0] ei, input string tag);
    int n = 0;
    while (!b_valid && n < 30) begin tick(); n++; end
    chk({tag, "_b_bound"}, 64'(n < 30), 64'd1);
    chk({tag, "_bresp"}, 64'(b_resp), 64'(er));
    chk({tag, "_bid"}, 64'(b_id), 64'(ei));
    tick();
    chk({tag, "_bvalid_drop"}, 64'(b_valid), 64'd0);
    chk({tag, "_awready_back"}, 64'(aw_ready), 64'd1);
  endtask

  initial begin
    // Reset state
    tick(); tick(); tick();
    chk("rst_awready", 64'(aw_ready), 64'd0);
    chk("rst_wready", 64'(w_ready), 64'd0);
    chk("rst_bvalid", 64'(b_valid), 64'd0);
    chk("rst_bresp", 64'(b_resp), 64'd0);
    chk("rst_bid", 64'(b_id), 64'd0);
    rst = 1'b0;
    chk("awready_first_cycle", 64'(aw_ready), 64'd0);
    tick();
    chk("awready_after_rst", 64'(aw_ready), 64'd1);

    // W before AW is stalled
    w_valid = 1'b1; w_data = 64'hDEAD; w_strb = 8'hFF;
    tick();
    chk("idle_wready", 64'(w_ready), 64'd0);
    w_valid = 1'b0;

    // INCR burst with exact response latency
    b_ready = 1'b1;
    aw_send(1'b1, 32'h10, 8'd3, 3'd3, 2'b01);
    w_send(64'h1111_1111_1111_1111, 8'hFF, 1'b0);
    w_send(64'h2222_2222_2222_2222, 8'hFF, 1'b0);
    w_send(64'h3333_3333_3333_3333, 8'hFF, 1'b0);
    w_send(64'h4444_4444_4444_4444, 8'hFF, 1'b1);
    chk("incr_wready_drop", 64'(w_ready), 64'd0);
    chk("incr_lat0", 64'(b_valid), 64'd0);
    tick();
    chk("incr_lat1", 64'(b_valid), 64'd0);
    tick();
    chk("incr_lat2", 64'(b_valid), 64'd0);
    tick();
    chk("incr_lat3", 64'(b_valid), 64'd1);
    finish_b(2'b00, 1'b1, "incr");
    chk_mem(2, 64'h1111_1111_1111_1111, "incr_w2");
    chk_mem(3, 64'h2222_2222_2222_2222, "incr_w3");
    chk_mem(4, 64'h3333_3333_3333_3333, "incr_w4");
    chk_mem(5, 64'h4444_4444_4444_4444, "incr_w5");

    // WRAP burst: 0x18 -> words 3,0,1,2
    aw_send(1'b0, 32'h18, 8'd3, 3'd3, 2'b10);
    w_send(64'hA0A0_A0A0_0000_0003, 8'hFF, 1'b0);
    w_send(64'hA1A1_A1A1_0000_0000, 8'hFF, 1'b0);
    w_send(64'hA2A2_A2A2_0000_0001, 8'hFF, 1'b0);
    w_send(64'hA3A3_A3A3_0000_0002, 8'hFF, 1'b1);
    finish_b(2'b00, 1'b0, "wrap");
    chk_mem(3, 64'hA0A0_A0A0_0000_0003, "wrap_w3");
    chk_mem(0, 64'hA1A1_A1A1_0000_0000, "wrap_w0");
    chk_mem(1, 64'hA2A2_A2A2_0000_0001, "wrap_w1");
    chk_mem(2, 64'hA3A3_A3A3_0000_0002, "wrap_w2");

    // FIXED burst: both beats land on word 4
    aw_send(1'b1, 32'h20, 8'd1, 3'd3, 2'b00);
    w_send(64'hF0F0_F0F0_F0F0_F0F0, 8'hFF, 1'b0);
    w_send(64'hF1F1_F1F1_F1F1_F1F1, 8'hFF, 1'b1);
    finish_b(2'b00, 1'b1, "fixed");
    chk_mem(4, 64'hF1F1_F1F1_F1F1_F1F1, "fixed_w4");
    chk_mem(5, 64'h4444_4444_4444_4444, "fixed_w5");

    // Out-of-range word 256 must not alias to word 0
    aw_send(1'b0, 32'h800, 8'd0, 3'd3, 2'b01);
    w_send(64'hBAD0_BAD0_BAD0_BAD0, 8'hFF, 1'b1);
    finish_b(2'b10, 1'b0, "oor");
    chk_mem(0, 64'hA1A1_A1A1_0000_0000, "oor_w0");

    // Reserved burst type: SLVERR, no write
    aw_send(1'b1, 32'h10, 8'd0, 3'd3, 2'b11);
    w_send(64'hBAD1_BAD1_BAD1_BAD1, 8'hFF, 1'b1);
    finish_b(2'b10, 1'b1, "rsvd");
    chk_mem(2, 64'hA3A3_A3A3_0000_0002, "rsvd_w2");

    // Early WLAST with partial strobes
    aw_send(1'b0, 32'h40, 8'd1, 3'd3, 2'b01);
    w_send(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0);
    w_send(64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b1);
    finish_b(2'b00, 1'b0, "prefill");
    aw_send(1'b1, 32'h40, 8'd3, 3'd3, 2'b01);
    w_send(64'h0123_4567_89AB_CDEF, 8'h0F, 1'b0);
    w_send(64'hFEDC_BA98_7654_3210, 8'h0F, 1'b1);
    chk("early_wready_drop", 64'(w_ready), 64'd0);
    finish_b(2'b10, 1'b1, "early");
    chk_mem(8, 64'hFFFF_FFFF_89AB_CDEF, "early_w8");
    chk_mem(9, 64'hFFFF_FFFF_7654_3210, "early_w9");

    // Missing WLAST, response held while b_ready is low
    b_ready = 1'b0;
    aw_send(1'b0, 32'h60, 8'd0, 3'd3, 2'b01);
    w_send(64'h5555_5555_5555_5555, 8'hFF, 1'b0);
    tick(); tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("hold_bvalid", 64'(b_valid), 64'd1);
      chk("hold_bresp", 64'(b_resp), 64'd2);
      chk("hold_bid", 64'(b_id), 64'd0);
      chk("hold_awready", 64'(aw_ready), 64'd0);
      tick();
    end
    b_ready = 1'b1;
    tick();
    chk("hold_bvalid_drop", 64'(b_valid), 64'd0);
    chk("hold_awready_back", 64'(aw_ready), 64'd1);
    chk_mem(12, 64'h5555_5555_5555_5555, "hold_w12");

    // Reset mid-burst
    aw_send(1'b1, 32'h80, 8'd3, 3'd3, 2'b01);
    w_send(64'h7777_0000_7777_0000, 8'hFF, 1'b0);
    w_send(64'h7777_1111_7777_1111, 8'hFF, 1'b0);
    rst = 1'b1;
    tick();
    chk("midrst_awready", 64'(aw_ready), 64'd0);
    chk("midrst_wready", 64'(w_ready), 64'd0);
    chk("midrst_bvalid", 64'(b_valid), 64'd0);
    chk("midrst_bid", 64'(b_id), 64'd0);
    rst = 1'b0;
    tick();
    chk("midrst_awready_back", 64'(aw_ready), 64'd1);
    chk_mem(16, 64'h7777_0000_7777_0000, "midrst_w16");
    chk_mem(17, 64'h7777_1111_7777_1111, "midrst_w17");
    aw_send(1'b1, 32'h90, 8'd0, 3'd3, 2'b01);
    w_send(64'h9999_9999_9999_9999, 8'hFF, 1'b1);
    finish_b(2'b00, 1'b1, "post_rst");
    chk_mem(18, 64'h9999_9999_9999_9999, "post_rst_w18");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
